// File: rtl/pc_sequencer.sv
// Program counter with a LIFO return-address stack: sequential, jump, call,
// return and PC-relative branch flows, plus sticky overflow/underflow flags.
module pc_sequencer #(
  parameter int                  PC_WIDTH     = 12,
  parameter int                  OFFSET_WIDTH = 8,
  parameter int                  STACK_DEPTH  = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  stall,
  input  logic [1:0]                            pc_src,
  input  logic                                  call,
  input  logic [PC_WIDTH-1:0]                   jump_target,
  input  logic [OFFSET_WIDTH-1:0]               branch_offset,
  input  logic                                  clear_flags,
  output logic [PC_WIDTH-1:0]                   pc,
  output logic [PC_WIDTH-1:0]                   stack_top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]      stack_count,
  output logic                                  stack_empty,
  output logic                                  stack_full,
  output logic                                  stack_overflow,
  output logic                                  stack_underflow
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int AW = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'b00,
    SRC_JUMP   = 2'b01,
    SRC_RET    = 2'b10,
    SRC_BRANCH = 2'b11
  } src_e;

  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [AW-1:0]       top_idx;
  logic [PC_WIDTH-1:0] top_entry;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] offset_ext;
  logic [PC_WIDTH-1:0] next_pc;
  logic                do_push;
  logic                do_pop;
  logic                ovf_set;
  logic                udf_set;

  // Storage is read straight from the registered count, so a push is visible
  // as the new top on the very next cycle without any forwarding.
  assign top_idx     = AW'(stack_count - CW'(1));
  assign top_entry   = stack_mem[top_idx];
  assign stack_empty = (stack_count == '0);
  assign stack_full  = (stack_count == CW'(STACK_DEPTH));
  assign stack_top   = stack_empty ? '0 : top_entry;

  assign pc_inc     = pc + PC_WIDTH'(1);
  assign offset_ext = PC_WIDTH'(signed'(branch_offset));

  // NOTE: every always_comb output gets a default first so no path can hold
  // its old value, which would infer a latch.
  always_comb begin
    next_pc = pc_inc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    case (src_e'(pc_src))
      SRC_SEQ: ;
      SRC_JUMP: begin
        next_pc = jump_target;
        if (call) begin
          if (stack_full) ovf_set = 1'b1;
          else            do_push = 1'b1;
        end
      end
      SRC_RET: begin
        if (stack_empty) begin
          udf_set = 1'b1;
        end else begin
          next_pc = top_entry;
          do_pop  = 1'b1;
        end
      end
      SRC_BRANCH: next_pc = pc_inc + offset_ext;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc              <= RESET_PC;
      stack_count     <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      if (!stall) begin
        pc <= next_pc;
        if (do_push)     stack_count <= stack_count + CW'(1);
        else if (do_pop) stack_count <= stack_count - CW'(1);
      end
      // Clearing is honoured even while stalled; a same-cycle set wins.
      stack_overflow  <= (stack_overflow  & ~clear_flags) | (ovf_set & ~stall);
      stack_underflow <= (stack_underflow & ~clear_flags) | (udf_set & ~stall);
    end
  end

  // NOTE: the stack storage is deliberately not reset; entries at or above
  // the count are never visible, so only the count needs clearing.
  always_ff @(posedge clk) begin
    if (rst_n && !stall && do_push) stack_mem[AW'(stack_count)] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer at default parameters.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  pc_src;
  logic        call;
  logic [11:0] jump_target;
  logic [7:0]  branch_offset;
  logic        clear_flags;
  logic [11:0] pc;
  logic [11:0] stack_top;
  logic [3:0]  stack_count;
  logic        stack_empty;
  logic        stack_full;
  logic        stack_overflow;
  logic        stack_underflow;

  int total = 0;
  int bad   = 0;
  logic [11:0] pushed [9];

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_src(pc_src), .call(call),
    .jump_target(jump_target), .branch_offset(branch_offset),
    .clear_flags(clear_flags), .pc(pc), .stack_top(stack_top),
    .stack_count(stack_count), .stack_empty(stack_empty),
    .stack_full(stack_full), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] src, input logic c, input logic [11:0] tgt,
                       input logic [7:0] off, input logic clr);
    pc_src = src; call = c; jump_target = tgt; branch_offset = off; clear_flags = clr;
    step();
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; pc_src = 2'b00; call = 1'b0;
    jump_target = '0; branch_offset = '0; clear_flags = 1'b0;

    // Reset held two cycles, then sequential flow.
    step(); step();
    check("rst_pc", pc, 12'h000);
    check("rst_count", stack_count, 0);
    check("rst_empty", stack_empty, 1);
    check("rst_full", stack_full, 0);
    check("rst_top", stack_top, 0);
    check("rst_ovf", stack_overflow, 0);
    check("rst_udf", stack_underflow, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(2'b00, 0, 0, 0, 0);
      check($sformatf("seq_pc%0d", i), pc, i);
    end
    check("seq_empty", stack_empty, 1);

    // Branches and wrap.
    drive(2'b01, 0, 12'h005, 0, 0);
    check("jump_pc", pc, 12'h005);
    drive(2'b11, 0, 0, 8'hFD, 0);
    check("branch_back", pc, 12'h003);
    drive(2'b01, 0, 12'hFFF, 0, 0);
    drive(2'b00, 0, 0, 0, 0);
    check("seq_wrap", pc, 12'h000);
    drive(2'b01, 0, 12'hFFE, 0, 0);
    drive(2'b11, 0, 0, 8'h7F, 0);
    check("branch_wrap", pc, 12'h07E);

    // Nested call / return, including call followed directly by return.
    drive(2'b01, 0, 12'h010, 0, 0);
    drive(2'b01, 1, 12'h100, 0, 0);
    check("call1_pc", pc, 12'h100);
    check("call1_cnt", stack_count, 1);
    check("call1_top", stack_top, 12'h011);
    check("call1_empty", stack_empty, 0);
    drive(2'b01, 1, 12'h200, 0, 0);
    check("call2_pc", pc, 12'h200);
    check("call2_cnt", stack_count, 2);
    check("call2_top", stack_top, 12'h101);
    drive(2'b10, 0, 0, 0, 0);
    check("ret1_pc", pc, 12'h101);
    check("ret1_cnt", stack_count, 1);
    drive(2'b10, 0, 0, 0, 0);
    check("ret2_pc", pc, 12'h011);
    check("ret2_cnt", stack_count, 0);
    check("ret2_top", stack_top, 0);

    // Overflow: nine calls into an eight-deep stack.
    for (int i = 0; i < 9; i++) begin
      pushed[i] = pc + 12'h001;
      drive(2'b01, 1, 12'h300 + 12'(i * 16), 0, 0);
      if (i == 7) begin
        check("fill_cnt", stack_count, 8);
        check("fill_full", stack_full, 1);
        check("fill_ovf", stack_overflow, 0);
      end
    end
    check("ovf_pc", pc, 12'h380);
    check("ovf_cnt", stack_count, 8);
    check("ovf_full", stack_full, 1);
    check("ovf_flag", stack_overflow, 1);
    check("ovf_top", stack_top, 12'h361);
    for (int i = 7; i >= 0; i--) begin
      drive(2'b10, 0, 0, 0, 0);
      check($sformatf("unwind_pc%0d", i), pc, pushed[i]);
    end
    check("unwind_cnt", stack_count, 0);
    check("unwind_ovf", stack_overflow, 1);
    drive(2'b00, 0, 0, 0, 1);
    check("ovf_clear", stack_overflow, 0);

    // Underflow and the clear/set race.
    drive(2'b01, 0, 12'h020, 0, 0);
    drive(2'b10, 0, 0, 0, 0);
    check("udf_pc", pc, 12'h021);
    check("udf_flag", stack_underflow, 1);
    check("udf_cnt", stack_count, 0);
    drive(2'b10, 0, 0, 0, 1);
    check("udf_race_pc", pc, 12'h022);
    check("udf_race", stack_underflow, 1);
    drive(2'b00, 0, 0, 0, 1);
    check("udf_clear", stack_underflow, 0);
    check("udf_clear_pc", pc, 12'h023);

    // Stall and mid-sequence reset.
    drive(2'b01, 1, 12'h400, 0, 0);
    drive(2'b01, 1, 12'h410, 0, 0);
    drive(2'b01, 1, 12'h420, 0, 0);
    check("pre_stall_cnt", stack_count, 3);
    check("pre_stall_top", stack_top, 12'h411);
    stall = 1'b1;
    drive(2'b01, 1, 12'h500, 0, 0);
    check("stall_pc", pc, 12'h420);
    check("stall_cnt", stack_count, 3);
    check("stall_top", stack_top, 12'h411);
    rst_n = 1'b0;
    drive(2'b01, 1, 12'h500, 0, 0);
    check("mid_rst_cnt", stack_count, 0);
    check("mid_rst_pc", pc, 12'h000);
    check("mid_rst_top", stack_top, 0);
    check("mid_rst_empty", stack_empty, 1);
    rst_n = 1'b1; stall = 1'b0;
    drive(2'b00, 0, 0, 0, 0);
    check("post_rst_pc", pc, 12'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
